// File: rtl/wb_pkg.sv
// Shared constants and requester identifiers for the writeback port arbiter.
package wb_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 2;
    localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

    typedef enum logic {
        WB_ALU  = 1'b0,
        WB_LOAD = 1'b1
    } wb_req_id_t;

endpackage

// File: rtl/wb_rr_arb2.sv
// Combinational 2-way writeback grant; round-robin on ties when WB_RR_ARB_EN is
// defined, otherwise the load path (requester 1) always wins ties.
module wb_rr_arb2
    import wb_pkg::*;
(
    input  logic [1:0] req_valid_i,
    input  wb_req_id_t grant_last_i,
    input  logic       wb_hold_i,
    output logic [1:0] grant_o
);

`ifndef WB_RR_ARB_EN
    // grant_last only matters for round-robin; kept on the port for a uniform interface.
    logic unused_grant_last;
    assign unused_grant_last = grant_last_i;
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        grant_o = 2'b00;
        if (!wb_hold_i) begin
            case (req_valid_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
`ifdef WB_RR_ARB_EN
                2'b11:   grant_o = (grant_last_i == WB_LOAD) ? 2'b01 : 2'b10;
`else
                2'b11:   grant_o = 2'b10;
`endif
                default: grant_o = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: registered register-file write stage, grant history and
// busy scoreboard. Tie policy selected by WB_RR_ARB_EN (see wb_rr_arb2).
module wb_port_arbiter
    import wb_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [ADDR_WIDTH-1:0] req_reg0,
    input  logic [ADDR_WIDTH-1:0] req_reg1,
    input  logic [DATA_WIDTH-1:0] req_data0,
    input  logic [DATA_WIDTH-1:0] req_data1,
    input  logic                  wb_hold,
    input  logic                  claim_valid,
    input  logic [ADDR_WIDTH-1:0] claim_reg,
    output logic [ADDR_WIDTH-1:0] write_reg,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  reg_write,
    output logic [NUM_REGS-1:0]   busy,
    output logic                  grant_last
);

    logic [1:0]            grant;
    logic                  xfer;
    logic [ADDR_WIDTH-1:0] write_reg_q,  write_reg_d;
    logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
    logic                  reg_write_q,  reg_write_d;
    logic [NUM_REGS-1:0]   busy_q,       busy_d;
    wb_req_id_t            grant_last_q, grant_last_d;

    // Reset blocks acceptance combinationally so nothing is taken in a reset cycle.
    wb_rr_arb2 u_arb (
        .req_valid_i  (req_valid),
        .grant_last_i (grant_last_q),
        .wb_hold_i    (wb_hold | reset),
        .grant_o      (grant)
    );

    assign req_ready = grant;
    assign xfer      = |(req_valid & grant);

    always_comb begin
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        reg_write_d  = 1'b0;
        grant_last_d = grant_last_q;
        if (xfer) begin
            reg_write_d = 1'b1;
            if (grant[1]) begin
                write_reg_d  = req_reg1;
                write_data_d = req_data1;
                grant_last_d = WB_LOAD;
            end else begin
                write_reg_d  = req_reg0;
                write_data_d = req_data0;
                grant_last_d = WB_ALU;
            end
        end

        // Claim is applied after the commit clear so a same-register claim wins.
        busy_d = busy_q;
        if (reg_write_q) busy_d[write_reg_q] = 1'b0;
        if (claim_valid) busy_d[claim_reg]   = 1'b1;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            write_reg_q  <= '0;
            write_data_q <= '0;
            reg_write_q  <= 1'b0;
            busy_q       <= '0;
            grant_last_q <= WB_LOAD;
        end else begin
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            reg_write_q  <= reg_write_d;
            busy_q       <= busy_d;
            grant_last_q <= grant_last_d;
        end
    end

    assign write_reg  = write_reg_q;
    assign write_data = write_data_q;
    assign reg_write  = reg_write_q;
    assign busy       = busy_q;
    assign grant_last = grant_last_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: a reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_wb_port_arbiter;
    import wb_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [ADDR_WIDTH-1:0] req_reg0, req_reg1;
    logic [DATA_WIDTH-1:0] req_data0, req_data1;
    logic                  wb_hold;
    logic                  claim_valid;
    logic [ADDR_WIDTH-1:0] claim_reg;
    logic [ADDR_WIDTH-1:0] write_reg;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  reg_write;
    logic [NUM_REGS-1:0]   busy;
    logic                  grant_last;

    wb_port_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_reg0    (req_reg0),
        .req_reg1    (req_reg1),
        .req_data0   (req_data0),
        .req_data1   (req_data1),
        .wb_hold     (wb_hold),
        .claim_valid (claim_valid),
        .claim_reg   (claim_reg),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .reg_write   (reg_write),
        .busy        (busy),
        .grant_last  (grant_last)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    endtask

    // Reference model: what the register-file port and scoreboard must show.
    bit       model_ok = 1'b0;
    bit       m_we;
    int       m_wreg, m_wdata, m_last;
    bit [3:0] m_busy;

    function automatic logic [1:0] exp_ready();
        int pick;
        if (reset || wb_hold || req_valid == 2'b00) return 2'b00;
        if (req_valid == 2'b01) return 2'b01;
        if (req_valid == 2'b10) return 2'b10;
`ifdef WB_RR_ARB_EN
        pick = 1 - m_last;
`else
        pick = 1;
`endif
        return (pick == 1) ? 2'b10 : 2'b01;
    endfunction

    always @(posedge clk) begin
        logic [1:0] r;
        bit [3:0]   nb;
        if (reset) begin
            m_we = 0; m_wreg = 0; m_wdata = 0; m_busy = '0; m_last = 1;
            model_ok = 1'b1;
        end else if (model_ok) begin
            r  = exp_ready();
            nb = m_busy;
            if (m_we) nb[m_wreg] = 1'b0;
            if (claim_valid) nb[claim_reg] = 1'b1;
            m_busy = nb;
            if (r == 2'b10) begin
                m_we = 1; m_wreg = int'(req_reg1); m_wdata = int'(req_data1); m_last = 1;
            end else if (r == 2'b01) begin
                m_we = 1; m_wreg = int'(req_reg0); m_wdata = int'(req_data0); m_last = 0;
            end else begin
                m_we = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("m_ready",      32'(req_ready),  32'(exp_ready()));
            check("m_reg_write",  32'(reg_write),  32'(m_we));
            check("m_write_reg",  32'(write_reg),  32'(m_wreg));
            check("m_write_data", 32'(write_data), 32'(m_wdata));
            check("m_busy",       32'(busy),       32'(m_busy));
            check("m_grant_last", 32'(grant_last), 32'(m_last));
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] rr_seq [4];

    initial begin
`ifdef WB_RR_ARB_EN
        rr_seq[0] = 2'b01; rr_seq[1] = 2'b10; rr_seq[2] = 2'b01; rr_seq[3] = 2'b10;
`else
        rr_seq[0] = 2'b10; rr_seq[1] = 2'b10; rr_seq[2] = 2'b10; rr_seq[3] = 2'b10;
`endif
        reset = 1'b1; req_valid = 2'b11; wb_hold = 1'b0;
        req_reg0 = 0; req_reg1 = 0; req_data0 = 0; req_data1 = 0;
        claim_valid = 1'b0; claim_reg = 0;

        // Reset held two cycles with both requesters valid.
        #1;
        @(negedge clk); check("rst_ready0", 32'(req_ready), 32'h0);
        next_cycle();
        @(negedge clk); check("rst_ready1", 32'(req_ready), 32'h0);
        next_cycle();
        reset = 1'b0; req_valid = 2'b00;
        @(negedge clk);
        check("rst_reg_write",  32'(reg_write),  32'h0);
        check("rst_busy",       32'(busy),       32'h0);
        check("rst_write_reg",  32'(write_reg),  32'h0);
        check("rst_write_data", 32'(write_data), 32'h0);
        check("rst_grant_last", 32'(grant_last), 32'h1);

        // Both requesters valid for four cycles.
        req_reg0 = 2'd0; req_data0 = 16'h1111; req_reg1 = 2'd1; req_data1 = 16'h2222;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            req_valid = 2'b11;
            @(negedge clk);
            check($sformatf("rr_grant%0d", i), 32'(req_ready), 32'(rr_seq[i]));
            if (i > 0) check($sformatf("rr_we%0d", i), 32'(reg_write), 32'h1);
        end
        next_cycle();
        req_valid = 2'b00;
        @(negedge clk); check("rr_we4", 32'(reg_write), 32'h1);

        // Single, unclaimed write from the ALU path.
        next_cycle();
        req_valid = 2'b01; req_reg0 = 2'd2; req_data0 = 16'hBEEF;
        @(negedge clk); check("single_ready", 32'(req_ready), 32'h1);
        next_cycle();
        req_valid = 2'b00;
        @(negedge clk);
        check("single_we",    32'(reg_write),  32'h1);
        check("single_reg",   32'(write_reg),  32'h2);
        check("single_data",  32'(write_data), 32'hBEEF);
        check("single_glast", 32'(grant_last), 32'h0);
        next_cycle();
        @(negedge clk);
        check("idle_we",   32'(reg_write), 32'h0);
        check("idle_hold", 32'(write_reg), 32'h2);
        check("unclaimed", 32'(busy),      32'h0);

        // Claim r3, commit from the load path two cycles later.
        next_cycle();
        claim_valid = 1'b1; claim_reg = 2'd3;
        next_cycle();
        claim_valid = 1'b0;
        @(negedge clk); check("sb_set", 32'(busy[3]), 32'h1);
        next_cycle();
        req_valid = 2'b10; req_reg1 = 2'd3; req_data1 = 16'hABCD;
        @(negedge clk); check("sb_ready", 32'(req_ready), 32'h2);
        next_cycle();
        req_valid = 2'b00;
        @(negedge clk);
        check("sb_commit_we", 32'(reg_write), 32'h1);
        check("sb_still",     32'(busy[3]),   32'h1);
        next_cycle();
        @(negedge clk); check("sb_clear", 32'(busy[3]), 32'h0);

        // Same again, but r3 is re-claimed in the commit cycle.
        next_cycle();
        claim_valid = 1'b1; claim_reg = 2'd3;
        next_cycle();
        claim_valid = 1'b0;
        req_valid = 2'b10; req_reg1 = 2'd3; req_data1 = 16'h4321;
        next_cycle();
        req_valid = 2'b00; claim_valid = 1'b1; claim_reg = 2'd3;
        @(negedge clk); check("sb_reclaim_we", 32'(reg_write), 32'h1);
        next_cycle();
        claim_valid = 1'b0;
        @(negedge clk); check("sb_reclaim", 32'(busy[3]), 32'h1);

        // Hold rises while a write sits in the output stage.
        next_cycle();
        req_valid = 2'b01; req_reg0 = 2'd1; req_data0 = 16'h5A5A; req_data1 = 16'h7777;
        next_cycle();
        wb_hold = 1'b1; req_valid = 2'b11;
        @(negedge clk);
        check("hold_ready0", 32'(req_ready), 32'h0);
        check("hold_we",     32'(reg_write), 32'h1);
        check("hold_data",   32'(write_data), 32'h5A5A);
        next_cycle();
        @(negedge clk);
        check("hold_ready1", 32'(req_ready), 32'h0);
        check("hold_idle",   32'(reg_write), 32'h0);
        next_cycle();
        wb_hold = 1'b0;
        @(negedge clk); check("hold_resume", 32'(req_ready), 32'h2);
        next_cycle();
        req_valid = 2'b00;
        @(negedge clk); check("hold_resume_data", 32'(write_data), 32'h7777);

        // Reset the cycle after a transfer to a claimed r1.
        next_cycle();
        claim_valid = 1'b1; claim_reg = 2'd1;
        req_valid = 2'b01; req_reg0 = 2'd1; req_data0 = 16'h1234;
        next_cycle();
        claim_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        check("mid_we_pending", 32'(reg_write), 32'h1);
        check("mid_busy1",      32'(busy[1]),   32'h1);
        check("mid_ready",      32'(req_ready), 32'h0);
        next_cycle();
        reset = 1'b0; req_valid = 2'b00;
        @(negedge clk);
        check("mid_we_drop", 32'(reg_write), 32'h0);
        check("mid_busy",    32'(busy),      32'h0);
        check("mid_glast",   32'(grant_last), 32'h1);

        next_cycle();
        next_cycle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
